// File: rtl/vga_pkg.sv
// Shared timing defaults, dither mode encodings and Bayer threshold lookup for the scan-out path.
// Pure declarations: no state, no latency.
package vga_pkg;

    localparam int H_DISPLAY_DEF = 1220;
    localparam int H_FRONT_DEF   = 31;
    localparam int H_SYNC_DEF    = 183;
    localparam int H_BACK_DEF    = 91;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int DM_TRUNC    = 0;
    localparam int DM_BAYER4   = 1;
    localparam int DM_BAYER8   = 2;
    localparam int DM_BAYER8X4 = 3;

    // One delay-line slot; sync/active flags are stored active-high, polarity applied at the pins.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic [2:0] i;
        logic [2:0] j;
        logic       f;
    } tap_t;

    function automatic int threshold_bits(input int mode);
        case (mode)
            DM_BAYER4:   return 4;
            DM_BAYER8:   return 6;
            DM_BAYER8X4: return 5;
            default:     return 0;
        endcase
    endfunction

    // MSB-first {x0, i0, x1, i1, ...} with x = i ^ j, i.e. bit_reverse(interleave(x, i)).
    function automatic logic [5:0] bayer_threshold(input int mode, input logic [2:0] i,
                                                   input logic [2:0] j, input logic f);
        logic [2:0] x;
        x = i ^ j;
        case (mode)
            DM_BAYER4:   bayer_threshold = {2'b00, x[0], i[0], x[1], i[1]};
            DM_BAYER8:   bayer_threshold = {x[0], i[0], x[1], i[1], x[2], i[2]};
            DM_BAYER8X4: bayer_threshold = {1'b0, i[0] ^ f, x[1], i[1], x[2], i[2]};
            default:     bayer_threshold = '0;
        endcase
    endfunction

endpackage

// File: rtl/ordered_dither.sv
// Single-channel ordered dither IN_W -> OUT_W with saturating round-up; purely combinational.
// No handshake: output follows inputs in the same cycle.
module ordered_dither import vga_pkg::*; #(
    parameter int IN_W  = 6,
    parameter int OUT_W = 2,
    parameter int MODE  = DM_BAYER8X4
) (
    input  logic [IN_W-1:0]  pix,
    input  logic [2:0]       i,
    input  logic [2:0]       j,
    input  logic             frame_lsb,
    output logic [OUT_W-1:0] pix_out
);

    localparam int D    = IN_W - OUT_W;
    localparam int K    = threshold_bits(MODE);
    localparam int SH_R = (K >= D) ? K - D : 0;
    localparam int SH_L = (K >= D) ? 0 : D - K;
    localparam logic [31:0] MAX_Q = 32'((1 << OUT_W) - 1);

    logic [31:0] thr;
    logic [31:0] sum;
    logic [31:0] q;

    // Sum never exceeds IN_W+1 bits, so 32-bit arithmetic is exact.
    always_comb begin
        thr = 32'(bayer_threshold(MODE, i, j, frame_lsb));
        sum = 32'(pix) + ((thr >> SH_R) << SH_L);
        q   = sum >> D;
        if (D == 0)
            pix_out = pix[OUT_W-1:0];
        else if (q > MAX_Q)
            pix_out = MAX_Q[OUT_W-1:0];
        else
            pix_out = q[OUT_W-1:0];
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA timing generator + dithered output stage; hsync/vsync/de lag counters by PIPE_LAT+1, pix_out lags pix_in by 1.
// Free-running with no backpressure: upstream must present a pixel every clock.
module vga_scanout import vga_pkg::*; #(
    parameter int H_DISPLAY   = H_DISPLAY_DEF,
    parameter int H_FRONT     = H_FRONT_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BACK      = H_BACK_DEF,
    parameter int V_DISPLAY   = V_DISPLAY_DEF,
    parameter int V_FRONT     = V_FRONT_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BACK      = V_BACK_DEF,
    parameter int HSYNC_POL   = 0,
    parameter int VSYNC_POL   = 0,
    parameter int CH          = 3,
    parameter int IN_W        = 6,
    parameter int OUT_W       = 2,
    parameter int PIPE_LAT    = 2,
    parameter int DITHER_MODE = DM_BAYER8X4
) (
    input  logic                  clk48,
    input  logic                  rst_n,
    input  logic                  pause_n,
    output logic [10:0]           h_count,
    output logic [9:0]            v_count,
    output logic [15:0]           frame,
    output logic                  line_start,
    output logic                  frame_start,
    input  logic [CH*IN_W-1:0]    pix_in,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [CH*OUT_W-1:0]   pix_out
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT   = 11'(H_DISPLAY);
    localparam logic [10:0] HS_BEG  = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END  = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT   = 10'(V_DISPLAY);
    localparam logic [9:0]  VS_BEG  = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]  VS_END  = 10'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic        HS_ON   = 1'(HSYNC_POL);
    localparam logic        VS_ON   = 1'(VSYNC_POL);

    logic                h_wrap;
    logic                v_wrap;
    tap_t                raw;
    tap_t                tap;
    logic [CH*OUT_W-1:0] dith;

    assign h_wrap      = (h_count == H_LAST);
    assign v_wrap      = (v_count == V_LAST);
    assign line_start  = (h_count == 11'd0);
    assign frame_start = (h_count == 11'd0) && (v_count == 10'd0);

    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            h_count <= '0;
            v_count <= '0;
            frame   <= '0;
        end else begin
            h_count <= h_wrap ? 11'd0 : h_count + 11'd1;
            if (h_wrap)
                v_count <= v_wrap ? 10'd0 : v_count + 10'd1;
            if (h_wrap && v_wrap && pause_n)
                frame <= frame + 16'd1;
        end
    end

    always_comb begin
        raw.hs  = (h_count >= HS_BEG) && (h_count < HS_END);
        raw.vs  = (v_count >= VS_BEG) && (v_count < VS_END);
        raw.act = (h_count < H_ACT) && (v_count < V_ACT);
        raw.i   = h_count[2:0];
        raw.j   = v_count[2:0];
        raw.f   = frame[0];
    end

    // Delay line matches the upstream effect pipeline so pix_in and its coordinates meet here.
    if (PIPE_LAT == 0) begin : g_nodly
        assign tap = raw;
    end else begin : g_dly
        tap_t stage [PIPE_LAT];
        always_ff @(posedge clk48) begin
            if (!rst_n) begin
                for (int k = 0; k < PIPE_LAT; k++) stage[k] <= '0;
            end else begin
                stage[0] <= raw;
                for (int k = 1; k < PIPE_LAT; k++) stage[k] <= stage[k-1];
            end
        end
        assign tap = stage[PIPE_LAT-1];
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        ordered_dither #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W),
            .MODE  (DITHER_MODE)
        ) u_dither (
            .pix       (pix_in[c*IN_W +: IN_W]),
            .i         (tap.i),
            .j         (tap.j),
            .frame_lsb (tap.f),
            .pix_out   (dith[c*OUT_W +: OUT_W])
        );
    end

    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            hsync   <= ~HS_ON;
            vsync   <= ~VS_ON;
            de      <= 1'b0;
            pix_out <= '0;
        end else begin
            hsync   <= tap.hs ? HS_ON : ~HS_ON;
            vsync   <= tap.vs ? VS_ON : ~VS_ON;
            de      <= tap.act;
            pix_out <= tap.act ? dith : '0;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: four instances (different latency/mode/polarity) on a shrunken raster,
// compared every cycle against an arithmetic model of counters, syncs and dither.
module tb_vga_scanout;

    localparam int HD = 16, HF = 3, HSY = 5, HB = 4;
    localparam int HT = HD + HF + HSY + HB;
    localparam int VD = 8, VF = 2, VSY = 2, VB = 3;
    localparam int VT = VD + VF + VSY + VB;
    localparam int NI = 4;
    localparam int MAXC = 8192;
    localparam int NCYC = 4800;

    localparam int PL_T   [NI] = '{2, 7, 0, 1};
    localparam int MODE_T [NI] = '{3, 0, 2, 1};
    localparam int HPOL_T [NI] = '{0, 1, 0, 0};
    localparam int VPOL_T [NI] = '{0, 0, 1, 0};

    logic        clk48 = 1'b0;
    logic        rst_n = 1'b0;
    logic        pause_n = 1'b1;
    logic [17:0] pix_in = '0;

    logic [10:0] hc [NI];
    logic [9:0]  vc [NI];
    logic [15:0] fc [NI];
    logic        ls [NI];
    logic        fs [NI];
    logic        hs [NI];
    logic        vs [NI];
    logic        de [NI];
    logic [5:0]  po [NI];

    int n_checks = 0;
    int n_errors = 0;
    int t = 0;
    int n = 0;
    int rst_left = 4;
    bit did_mid = 1'b0;
    int          frame_h [MAXC];
    logic [17:0] pix_h   [MAXC];

    always #5 clk48 = ~clk48;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        vga_scanout #(
            .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
            .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
            .HSYNC_POL(HPOL_T[g]), .VSYNC_POL(VPOL_T[g]),
            .CH(3), .IN_W(6), .OUT_W(2),
            .PIPE_LAT(PL_T[g]), .DITHER_MODE(MODE_T[g])
        ) u_dut (
            .clk48       (clk48),
            .rst_n       (rst_n),
            .pause_n     (pause_n),
            .h_count     (hc[g]),
            .v_count     (vc[g]),
            .frame       (fc[g]),
            .line_start  (ls[g]),
            .frame_start (fs[g]),
            .pix_in      (pix_in),
            .hsync       (hs[g]),
            .vsync       (vs[g]),
            .de          (de[g]),
            .pix_out     (po[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    function automatic int bayer_n(int i, int j, int nb);
        int x, th;
        x = i ^ j;
        th = 0;
        for (int b = 0; b < nb; b++)
            th = th * 4 + ((x >> b) & 1) * 2 + ((i >> b) & 1);
        return th;
    endfunction

    function automatic int dith_ref(int mode, int val, int i, int j, int f);
        int k, th, ts, q;
        case (mode)
            1: begin k = 4; th = bayer_n(i, j, 2); end
            2: begin k = 6; th = bayer_n(i, j, 3); end
            3: begin
                k = 5;
                th = (((i & 1) ^ f) * 16) + ((((i >> 1) ^ (j >> 1)) & 1) * 8)
                   + (((i >> 1) & 1) * 4) + ((((i >> 2) ^ (j >> 2)) & 1) * 2) + ((i >> 2) & 1);
            end
            default: begin k = 0; th = 0; end
        endcase
        ts = (k >= 4) ? (th >> (k - 4)) : (th << (4 - k));
        q = (val + ts) >> 4;
        return (q > 3) ? 3 : q;
    endfunction

    function automatic logic [5:0] pick();
        case ($urandom % 3)
            0:       return 6'h3F;
            1:       return 6'h20;
            default: return 6'h1F;
        endcase
    endfunction

    task automatic check_all();
        for (int g = 0; g < NI; g++) begin
            int td, hx, vy, ep;
            bit act, hs_a, vs_a;
            check($sformatf("u%0d h_count", g), hc[g], t % HT);
            check($sformatf("u%0d v_count", g), vc[g], (t / HT) % VT);
            check($sformatf("u%0d frame", g), fc[g], frame_h[t]);
            check($sformatf("u%0d line_start", g), ls[g], (t % HT) == 0);
            check($sformatf("u%0d frame_start", g), fs[g], (t % (HT * VT)) == 0);
            td = t - 1 - PL_T[g];
            act = 1'b0; hs_a = 1'b0; vs_a = 1'b0; ep = 0; hx = 0; vy = 0;
            if (td >= 0) begin
                hx = td % HT;
                vy = (td / HT) % VT;
                act  = (hx < HD) && (vy < VD);
                hs_a = (hx >= HD + HF) && (hx < HD + HF + HSY);
                vs_a = (vy >= VD + VF) && (vy < VD + VF + VSY);
            end
            if (act)
                for (int c = 0; c < 3; c++)
                    ep |= dith_ref(MODE_T[g], int'((pix_h[t-1] >> (6 * c)) & 18'h3F),
                                   hx & 7, vy & 7, frame_h[td] & 1) << (2 * c);
            check($sformatf("u%0d hsync", g), hs[g], hs_a ? HPOL_T[g] : 1 - HPOL_T[g]);
            check($sformatf("u%0d vsync", g), vs[g], vs_a ? VPOL_T[g] : 1 - VPOL_T[g]);
            check($sformatf("u%0d de", g), de[g], act);
            check($sformatf("u%0d pix_out", g), po[g], ep);
        end
    endtask

    initial begin
        frame_h[0] = 0;
        while (n < NCYC) begin
            @(negedge clk48);
            check_all();
            // Mid-frame reset once the late random phase reaches a fixed raster position.
            if (!did_mid && n >= 3700 && (t % HT) == 10 && ((t / HT) % VT) == 4) begin
                rst_left = 3;
                did_mid = 1'b1;
            end
            rst_n = (rst_left == 0);
            if (rst_left > 0) rst_left--;
            if (n < 1264) begin
                pix_in = 18'($urandom);
                pause_n = ($urandom % 8) != 0;
            end else if (n < 2104) begin
                pix_in = 18'h08208;
                pause_n = 1'b1;
            end else if (n < 3100) begin
                pix_in = {pick(), pick(), pick()};
                pause_n = 1'b0;
            end else if (n < 3700) begin
                pix_in = 18'h3FFFF;
                pause_n = 1'b1;
            end else begin
                pix_in = 18'($urandom);
                pause_n = ($urandom % 4) != 0;
            end
            if (!rst_n) begin
                t = 0;
            end else if (t + 1 < MAXC) begin
                pix_h[t] = pix_in;
                frame_h[t+1] = (frame_h[t] + (((t % HT) == HT - 1 && ((t / HT) % VT) == VT - 1
                                && pause_n) ? 1 : 0)) & 16'hFFFF;
                t++;
            end else begin
                n_errors++;
                $display("FAIL model_depth: got cycle %0d, expected below %0d", t, MAXC);
                n = NCYC;
            end
            n++;
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
Parametrised VGA scan-out engine: the next generation of the fixed 1220x480 timing-plus-dither output stage. It generates the h/v/frame counters consumed by effect generators. It accepts their per-pixel colour after a configurable pipeline latency, aligns sync and display-enable to that latency, and ordered-dithers CH channels from IN_W to OUT_W bits with selectable Bayer modes. It sits between the effect compositor and the board pins.

Parameters:
H_DISPLAY, 1220, active clocks per line
H_FRONT, 31, front porch clocks
H_SYNC, 183, hsync pulse clocks
H_BACK, 91, back porch clocks (H_TOTAL = sum = 1525)
V_DISPLAY, 480, active lines
V_FRONT, 10, front porch lines
V_SYNC, 2, vsync lines
V_BACK, 33, back porch lines (V_TOTAL = 525)
HSYNC_POL, 0, active sync level (0 = active-low)
VSYNC_POL, 0, active sync level
CH, 3, colour channels
IN_W, 6, input bits per channel
OUT_W, 2, output bits per channel (OUT_W <= IN_W)
PIPE_LAT, 2, upstream pixel latency in clocks (0..7)
DITHER_MODE, 3, 0 truncate, 1 Bayer 4x4, 2 Bayer 8x8, 3 Bayer 8x4 frame-toggled

Ports:
clk48  in  1  pixel clock
rst_n  in  1  reset
pause_n  in  1  frame counter advances only when high
h_count  out  11  horizontal counter
v_count  out  10  vertical counter
frame  out  16  frame counter
line_start  out  1  high while h_count==0
frame_start  out  1  high while h_count==0 and v_count==0
pix_in  in  CH*IN_W  colour for counters of PIPE_LAT clocks earlier; channel 0 in LSBs
hsync  out  1  registered
vsync  out  1  registered
de  out  1  registered display enable
pix_out  out  CH*OUT_W  registered dithered colour

Behaviour:
- Reset rst_n, synchronous, active-low; clock clk48.
- In reset: h_count, v_count and frame are 0. hsync/vsync at the inactive level. de=0, pix_out=0. All delay-line stages are flushed to inactive/0.
- First clock after release: counters read (0,0) and frame_start=1.
- h_count increments each clock and wraps H_TOTAL-1 -> 0. v_count increments on h wrap and wraps V_TOTAL-1 -> 0.
- frame increments by 1 (mod 2^16) on the cycle where both counters wrap, only if pause_n=1 that cycle.
- Raw hsync is active for H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC.
- Raw vsync is active for V_DISPLAY+V_FRONT <= v < V_DISPLAY+V_FRONT+V_SYNC.
- Raw active = h<H_DISPLAY && v<V_DISPLAY.
- Raw sync, active, h[2:0], v[2:0] and frame[0] pass through a PIPE_LAT-deep shift register, then the output register.
- hsync/vsync/de therefore lag the counters by exactly PIPE_LAT+1 clocks. pix_out lags pix_in by 1 clock and stays aligned with de.
- pix_out is 0 whenever the delayed active flag is 0.
- Dither per channel, D = IN_W-OUT_W:
  - Threshold t has k bits: 0 for mode 0, 4 for mode 1, 6 for mode 2, 5 for mode 3.
  - Scaled threshold t' = t>>(k-D) if k>=D, else t<<(D-k).
  - sum = in + t' in IN_W+1 bits. out = sum>>D, saturated to 2^OUT_W-1.
  - D=0 means passthrough.
- Bayer index uses the delayed i=h[2:0], j=v[2:0].
  - Modes 1/2: M = bit_reverse(interleave(i^j, i)) over 2/3 bit pairs.
  - Mode 3: i0' = i0^frame[0]; t = {i0', i1^j1, i1, i2^j2, i2}.
- Pause affects only frame. Counters and syncs keep running.
- Reset mid-frame aborts the frame: outputs go inactive the cycle reset is sampled, and timing restarts from (0,0).

Decomposition:
- vga_pkg holds:
  - default timing constants;
  - DITHER_MODE encodings;
  - bayer_threshold function (mode, i, j, frame bit).
- One sub-module, ordered_dither: a single channel, combinational, with IN_W/OUT_W/mode parameters. It is instantiated CH times by generate.
- vga_scanout keeps the counters, delay line and output registers.

Test Plan:
1. Defaults after reset -> hsync low for exactly 183 clocks starting 1251+3 clocks after line_start. Line period 1525; de high 1220 clocks per line.
2. Free-run -> vsync low on lines 490-491 (offset by 3 clocks). frame_start period 800625 clocks; frame increments by 1 per period.
3. pause_n=0 across two frame boundaries -> frame unchanged and syncs unaffected. pause_n=1 -> increments resume.
4. DITHER_MODE=0, pix_in channel 0x3F -> 2'b11; 0x20 -> 2'b10; 0x1F -> 2'b01. Blanking -> pix_out=0. PIPE_LAT=0,2,7 each keep de/pix_out alignment.
5. Mode 3, constant 8 (6-bit) -> exactly 16 of 32 positions output 1 across an even/odd frame pair. Constant 63 -> saturates to 3, never wraps.
6. rst_n low for 3 clocks at h=600, v=100 -> de=0, pix_out=0, syncs inactive. Counters at (0,0) with frame_start=1 on the first cycle after release.
